// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the exec_ctrl instruction controller.
//   - FSM state encoding (plain localparams so older tools and dumps agree)
//   - RV32 opcode constants for the supported R-type and I-type ALU groups
//   - alu_opcode layout helper: {3'b000, is_imm, f7b, funct3}
package exec_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // Shift-right funct3; the only I-type group where instr[30] selects the op
  localparam logic [2:0] FUNCT3_SR = 3'b101;

  // alu_opcode bit layout: [7:5] zero, [4] is_imm, [3] f7b, [2:0] funct3
  function automatic logic [7:0] pack_alu_opcode(input logic       is_imm,
                                                 input logic       f7b,
                                                 input logic [2:0] funct3);
    return {3'b000, is_imm, f7b, funct3};
  endfunction

endpackage

// File: rtl/exec_ctrl_decode.sv
// Combinational RV32 decoder for the R-type / I-type ALU subset.
// Ports:
//   instr      in  32  instruction word
//   legal      out 1   opcode is R-type or I-type ALU
//   is_imm     out 1   I-type (operand B is the immediate)
//   rs1_addr   out 5   source register 1
//   rs2_addr   out 5   source register 2 (0 for I-type)
//   rd_addr    out 5   destination register
//   imm        out 32  sign-extended instr[31:20]
//   alu_opcode out 8   packed ALU operation
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic        is_imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [7:0]  alu_opcode
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r;
  logic       f7b;

  // Field extraction and operation packing
  always_comb begin
    opcode   = instr[6:0];
    funct3   = instr[14:12];
    is_r     = (opcode == OP_R);
    is_imm   = (opcode == OP_I);
    legal    = is_r || is_imm;
    rs1_addr = instr[19:15];
    rs2_addr = is_r ? instr[24:20] : 5'd0;
    rd_addr  = instr[11:7];
    imm      = {{20{instr[31]}}, instr[31:20]};
    // instr[30] only distinguishes SUB/SRA and SRAI; for other I-type ops
    // it is just an immediate bit and must not leak into the opcode.
    f7b        = (is_r || (is_imm && funct3 == FUNCT3_SR)) ? instr[30] : 1'b0;
    alu_opcode = pack_alu_opcode(is_imm, f7b, funct3);
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execution controller: accepts one RV32 ALU instruction,
// reads the register file, drives an external ALU, and writes back.
// Sequence is IDLE -> READ -> EXEC -> WB -> IDLE (or IDLE -> ERR -> IDLE
// for unsupported opcodes), giving one instruction per four cycles.
// Ports:
//   cpu_clk, cpu_rst                  clock, synchronous active-high reset
//   instr_valid/instr/instr_ready     instruction handshake
//   rf_ce/rf_we/rf_*_addr/rf_wr_data  register file control
//   rf_rs1_data/rf_rs2_data           read data, one cycle after rf_ce
//   alu_opcode/alu_imm1/alu_imm2      ALU operation and operands
//   alu_result                        combinational ALU result
//   busy/done/illegal                 status (done/illegal are pulses)
//   retire_cnt/illegal_cnt            wrapping event counters
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic             rf_ce,
  output logic             rf_we,
  output logic [4:0]       rf_rs1_addr,
  output logic [4:0]       rf_rs2_addr,
  output logic [4:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  input  logic [31:0]      rf_rs1_data,
  input  logic [31:0]      rf_rs2_data,
  output logic [7:0]       alu_opcode,
  output logic [31:0]      alu_imm1,
  output logic [31:0]      alu_imm2,
  input  logic [31:0]      alu_result,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] instr_q;
  logic [31:0] result_q;
  logic [31:0] dec_in;
  logic        accept;

  logic        dec_legal;
  logic        dec_is_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic [7:0]  dec_alu_op;

  // In IDLE the decoder looks at the offered word so legality picks the
  // next state; afterwards it works from the captured copy.
  assign dec_in = (state_q == ST_IDLE) ? instr : instr_q;
  assign accept = (state_q == ST_IDLE) && instr_valid;

  exec_ctrl_decode u_decode (
    .instr      (dec_in),
    .legal      (dec_legal),
    .is_imm     (dec_is_imm),
    .rs1_addr   (dec_rs1),
    .rs2_addr   (dec_rs2),
    .rd_addr    (dec_rd),
    .imm        (dec_imm),
    .alu_opcode (dec_alu_op)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = dec_legal ? ST_READ : ST_ERR;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured instruction, result register and counters.
  // Counters step on entry to WB/ERR so the new count is visible in the
  // same cycle as the done/illegal pulse; reset wins over every update.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      result_q    <= '0;
      retire_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
      if (state_q == ST_EXEC) begin
        result_q   <= alu_result;
        retire_cnt <= retire_cnt + CNT_ONE;
      end
      if (accept && !dec_legal) illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

  // Output decode from the current state
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    rf_ce       = 1'b0;
    rf_we       = 1'b0;
    rf_rs1_addr = 5'd0;
    rf_rs2_addr = 5'd0;
    rf_wr_addr  = 5'd0;
    rf_wr_data  = 32'd0;
    alu_opcode  = 8'd0;
    alu_imm1    = 32'd0;
    alu_imm2    = 32'd0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_READ: begin
        rf_ce       = 1'b1;
        rf_rs1_addr = dec_rs1;
        rf_rs2_addr = dec_rs2;
      end
      ST_EXEC: begin
        rf_rs1_addr = dec_rs1;
        rf_rs2_addr = dec_rs2;
        alu_opcode  = dec_alu_op;
        alu_imm1    = rf_rs1_data;
        alu_imm2    = dec_is_imm ? dec_imm : rf_rs2_data;
      end
      ST_WB: begin
        rf_ce      = 1'b1;
        rf_we      = (dec_rd != 5'd0);
        rf_wr_addr = dec_rd;
        rf_wr_data = result_q;
        done       = 1'b1;
      end
      ST_ERR: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl with a behavioural register
// file (x1=5, x2=7 after reset) and an independent RV32 ALU model.
module tb_exec_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        rf_ce, rf_we;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] rf_rs1_data = 32'd0;
  logic [31:0] rf_rs2_data = 32'd0;
  logic [7:0]  alu_opcode;
  logic [31:0] alu_imm1, alu_imm2, alu_result;
  logic        busy, done, illegal;
  logic [31:0] retire_cnt, illegal_cnt;

  logic [31:0] regs [32];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;
  int          accepts;
  int          wr_snap;

  always #5 cpu_clk = ~cpu_clk;

  exec_ctrl #(.CNT_W(32)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_ce       (rf_ce),
    .rf_we       (rf_we),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .alu_opcode  (alu_opcode),
    .alu_imm1    (alu_imm1),
    .alu_imm2    (alu_imm2),
    .alu_result  (alu_result),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .retire_cnt  (retire_cnt),
    .illegal_cnt (illegal_cnt)
  );

  // Register file model: registered reads on rf_ce, writes on rf_we
  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'd0;
    end else begin
      if (rf_ce) begin
        rf_rs1_data <= regs[rf_rs1_addr];
        rf_rs2_data <= regs[rf_rs2_addr];
      end
      if (rf_we && rf_wr_addr != 5'd0) regs[rf_wr_addr] <= rf_wr_data;
    end
  end

  // Independent count of every write strobe the controller issues
  always @(posedge cpu_clk) begin
    if (rf_we) wr_count <= wr_count + 1;
  end

  // RV32 ALU model keyed on {is_imm, f7b, funct3}
  always_comb begin
    alu_result = 32'd0;
    case (alu_opcode[2:0])
      3'b000: alu_result = (alu_opcode[3] && !alu_opcode[4]) ? alu_imm1 - alu_imm2
                                                              : alu_imm1 + alu_imm2;
      3'b001: alu_result = alu_imm1 << alu_imm2[4:0];
      3'b010: alu_result = {31'd0, $signed(alu_imm1) < $signed(alu_imm2)};
      3'b011: alu_result = {31'd0, alu_imm1 < alu_imm2};
      3'b100: alu_result = alu_imm1 ^ alu_imm2;
      3'b101: alu_result = alu_opcode[3] ? 32'($signed(alu_imm1) >>> alu_imm2[4:0])
                                         : alu_imm1 >> alu_imm2[4:0];
      3'b110: alu_result = alu_imm1 | alu_imm2;
      default: alu_result = alu_imm1 & alu_imm2;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge cpu_clk);
    #1;
  endtask

  // Offer one instruction in IDLE; returns one cycle after the accept edge
  task automatic applyStimulus(input logic [31:0] word);
    instr_valid = 1'b1;
    instr       = word;
    stepCycle();
    instr_valid = 1'b0;
    instr       = 32'd0;
  endtask

  // Run a legal instruction through EXEC and WB, checking the key outputs
  task automatic runAlu(input string name, input logic [31:0] word,
                        input logic [7:0] exp_op, input logic [31:0] exp_b,
                        input logic [4:0] exp_rd, input logic [31:0] exp_res,
                        input logic [31:0] exp_retire);
    applyStimulus(word);
    stepCycle();
    checkOutput({name, "_op"}, {24'd0, alu_opcode}, {24'd0, exp_op});
    checkOutput({name, "_b"}, alu_imm2, exp_b);
    stepCycle();
    checkOutput({name, "_wr_addr"}, {27'd0, rf_wr_addr}, {27'd0, exp_rd});
    checkOutput({name, "_wr_data"}, rf_wr_data, exp_res);
    checkOutput({name, "_we"}, {31'd0, rf_we}, {31'd0, exp_rd != 5'd0});
    checkOutput({name, "_retire"}, retire_cnt, exp_retire);
    stepCycle();
  endtask

  initial begin
    cpu_rst     = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    stepCycle();
    stepCycle();
    checkOutput("rst_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_retire", retire_cnt, 32'd0);
    checkOutput("rst_illegal_cnt", illegal_cnt, 32'd0);
    checkOutput("rst_ce", {31'd0, rf_ce}, 32'd0);
    cpu_rst = 1'b0;

    // add x3,x1,x2 walked cycle by cycle
    applyStimulus(32'h002081B3);
    checkOutput("add_read_ce", {31'd0, rf_ce}, 32'd1);
    checkOutput("add_read_ready", {31'd0, instr_ready}, 32'd0);
    checkOutput("add_rs1", {27'd0, rf_rs1_addr}, 32'd1);
    checkOutput("add_rs2", {27'd0, rf_rs2_addr}, 32'd2);
    stepCycle();
    checkOutput("add_a", alu_imm1, 32'd5);
    checkOutput("add_b", alu_imm2, 32'd7);
    checkOutput("add_exec_ce", {31'd0, rf_ce}, 32'd0);
    stepCycle();
    checkOutput("add_we", {31'd0, rf_we}, 32'd1);
    checkOutput("add_wr_addr", {27'd0, rf_wr_addr}, 32'd3);
    checkOutput("add_wr_data", rf_wr_data, 32'd12);
    checkOutput("add_done", {31'd0, done}, 32'd1);
    checkOutput("add_retire", retire_cnt, 32'd1);
    stepCycle();
    checkOutput("add_idle_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("add_idle_done", {31'd0, done}, 32'd0);
    checkOutput("add_x3", regs[3], 32'd12);

    // addi x4,x1,-1: read port 2 address forced to 0
    applyStimulus(32'hFFF08213);
    checkOutput("addi_rs2", {27'd0, rf_rs2_addr}, 32'd0);
    stepCycle();
    checkOutput("addi_op", {24'd0, alu_opcode}, 32'h10);
    checkOutput("addi_b", alu_imm2, 32'hFFFFFFFF);
    stepCycle();
    checkOutput("addi_wr_addr", {27'd0, rf_wr_addr}, 32'd4);
    checkOutput("addi_wr_data", rf_wr_data, 32'd4);
    checkOutput("addi_retire", retire_cnt, 32'd2);
    stepCycle();

    // JAL is rejected
    applyStimulus(32'h0000006F);
    checkOutput("jal_illegal", {31'd0, illegal}, 32'd1);
    checkOutput("jal_illegal_cnt", illegal_cnt, 32'd1);
    checkOutput("jal_ce", {31'd0, rf_ce}, 32'd0);
    checkOutput("jal_we", {31'd0, rf_we}, 32'd0);
    checkOutput("jal_ready_err", {31'd0, instr_ready}, 32'd0);
    stepCycle();
    checkOutput("jal_ready_idle", {31'd0, instr_ready}, 32'd1);
    checkOutput("jal_illegal_drop", {31'd0, illegal}, 32'd0);
    checkOutput("jal_retire", retire_cnt, 32'd2);

    // add x0,x1,x2: retires without a write
    applyStimulus(32'h00208033);
    stepCycle();
    stepCycle();
    checkOutput("x0_ce", {31'd0, rf_ce}, 32'd1);
    checkOutput("x0_we", {31'd0, rf_we}, 32'd0);
    checkOutput("x0_done", {31'd0, done}, 32'd1);
    checkOutput("x0_retire", retire_cnt, 32'd3);
    stepCycle();

    // sub x5,x2,x1 / srai x6,x2,1 / xori x7,x1,0x400
    runAlu("sub", 32'h401102B3, 8'h08, 32'd5, 5'd5, 32'd2, 32'd4);
    runAlu("srai", 32'h40115313, 8'h1D, 32'h00000401, 5'd6, 32'd3, 32'd5);
    runAlu("xori", 32'h4000C393, 8'h14, 32'h00000400, 5'd7, 32'h00000405, 32'd6);

    // Reset in EXEC aborts add x3; valid is refused while reset is high
    wr_snap = wr_count;
    applyStimulus(32'h002081B3);
    stepCycle();
    cpu_rst = 1'b1;
    stepCycle();
    checkOutput("abort_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("abort_we", {31'd0, rf_we}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_retire", retire_cnt, 32'd0);
    checkOutput("abort_illegal_cnt", illegal_cnt, 32'd0);
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    stepCycle();
    checkOutput("rst_no_accept", {31'd0, busy}, 32'd0);
    checkOutput("abort_no_write", wr_count, wr_snap);
    cpu_rst = 1'b0;

    // Back-to-back with valid held: ready only every fourth cycle
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("b2b_ready_%0d", i), {31'd0, instr_ready},
                  {31'd0, (i % 4) == 0});
      if (instr_ready) accepts++;
      stepCycle();
    end
    instr_valid = 1'b0;
    checkOutput("b2b_accepts", accepts, 32'd3);
    checkOutput("b2b_retire", retire_cnt, 32'd3);
    checkOutput("b2b_x3", regs[3], 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
